axi_id_remap: RTL and testbench

AXI_ID_REMAP -- requirements
Module: axi_id_remap

---
 rtl/axi_id_remap_pkg.sv | 21 ++
 rtl/axi_bus.sv | 92 +++++++++
 rtl/axi_id_remap_table.sv | 113 +++++++++++
 rtl/axi_id_remap.sv | 140 ++++++++++++++
 tb/tb_axi_id_remap.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_id_remap_pkg.sv
// Shared types and helpers for the AXI ID remapper and its lookup tables.
package axi_id_remap_pkg;

    // Storage widths of one table entry; instances narrower than this keep the
    // upper bits at zero, so they never toggle and synthesis removes them.
    localparam int unsigned ID_MAX_WIDTH  = 32;
    localparam int unsigned CNT_MAX_WIDTH = 8;

    // One remap table entry: the upstream ID it stands for and how many
    // transactions are still outstanding on it (0 = free).
    typedef struct packed {
        logic [ID_MAX_WIDTH-1:0]  in_id;
        logic [CNT_MAX_WIDTH-1:0] cnt;
    } entry_t;

    // Bits needed to count 0..max_txns outstanding transactions.
    function automatic int unsigned cnt_width(input int unsigned max_txns);
        return $clog2(max_txns + 1);
    endfunction

endpackage

// File: rtl/axi_bus.sv
// Generic AXI4 bus bundle with master and slave views.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 0
);

    // A zero user width still needs a legal vector; the extra bit is unused.
    localparam int unsigned USER_BITS = (AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1;
    localparam int unsigned STRB_BITS = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [USER_BITS-1:0]      aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_BITS-1:0]      w_strb;
    logic                      w_last;
    logic [USER_BITS-1:0]      w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [USER_BITS-1:0]      b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [USER_BITS-1:0]      ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [USER_BITS-1:0]      r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi_id_remap_table.sv
// One ID remap table: picks an output ID for a request, counts outstanding
// transactions per entry and translates response IDs back to input IDs.
module axi_id_remap_table
    import axi_id_remap_pkg::*;
#(
    parameter int unsigned ID_IN_WIDTH     = 12,
    parameter int unsigned ID_OUT_WIDTH    = 4,
    parameter int unsigned MAX_TXNS_PER_ID = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // request side: candidate ID and the resulting selection
    input  logic [ID_IN_WIDTH-1:0]  req_id,
    output logic                    sel_valid,
    output logic [ID_OUT_WIDTH-1:0] sel_idx,
    input  logic                    push,
    // response side: completed transaction on entry rsp_idx
    input  logic                    pop,
    input  logic [ID_OUT_WIDTH-1:0] rsp_idx,
    output logic [ID_IN_WIDTH-1:0]  rsp_in_id
);

    localparam int unsigned TABLE_SIZE = 1 << ID_OUT_WIDTH;
    localparam int unsigned CW         = cnt_width(MAX_TXNS_PER_ID);
    localparam logic [CNT_MAX_WIDTH-1:0] CNT_LIMIT = CNT_MAX_WIDTH'(MAX_TXNS_PER_ID);

    entry_t                  table_q [TABLE_SIZE];
    logic [ID_MAX_WIDTH-1:0] req_ext;
    logic                    match_hit;
    logic                    match_full;
    logic [ID_OUT_WIDTH-1:0] match_idx;
    logic                    free_hit;
    logic [ID_OUT_WIDTH-1:0] free_idx;
    logic [TABLE_SIZE-1:0]   inc;
    logic [TABLE_SIZE-1:0]   dec;

    assign req_ext   = ID_MAX_WIDTH'(req_id);
    assign rsp_in_id = table_q[rsp_idx].in_id[ID_IN_WIDTH-1:0];

    // Select: reuse the entry already carrying this ID (stall if saturated),
    // otherwise take the lowest free entry. Registered state only.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves one unassigned, which would otherwise infer a latch.
        match_hit  = 1'b0;
        match_full = 1'b0;
        match_idx  = '0;
        free_hit   = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < TABLE_SIZE; i++) begin
            if ((table_q[i].cnt != '0) && (table_q[i].in_id == req_ext)) begin
                match_hit  = 1'b1;
                match_idx  = ID_OUT_WIDTH'(i);
                match_full = (table_q[i].cnt >= CNT_LIMIT);
            end
            if (!free_hit && (table_q[i].cnt == '0)) begin
                free_hit = 1'b1;
                free_idx = ID_OUT_WIDTH'(i);
            end
        end
        // A saturated match must stall rather than open a second entry for
        // the same ID, otherwise responses could overtake each other.
        sel_valid = match_hit ? !match_full : free_hit;
        sel_idx   = match_hit ? match_idx : free_idx;
    end

    // Per-entry increment/decrement strobes; a response on a free entry is
    // ignored so the counter cannot underflow.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < TABLE_SIZE; i++) begin
            inc[i] = push && sel_valid && (sel_idx == ID_OUT_WIDTH'(i));
            dec[i] = pop && (rsp_idx == ID_OUT_WIDTH'(i)) && (table_q[i].cnt != '0);
        end
    end

    // Entry update: allocate/increment on request, decrement on completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the table is a small register file whose cnt fields mean
            // "free", so every entry is reset, unlike a data-only RAM.
            for (int i = 0; i < TABLE_SIZE; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            // NOTE: state is written with <= so every entry samples the same
            // pre-edge table contents regardless of loop order.
            for (int i = 0; i < TABLE_SIZE; i++) begin
                if (inc[i]) begin
                    table_q[i].in_id <= req_ext;
                    if (!dec[i]) begin
                        table_q[i].cnt <= table_q[i].cnt + CNT_MAX_WIDTH'(1);
                    end
                end else if (dec[i]) begin
                    table_q[i].cnt <= table_q[i].cnt - CNT_MAX_WIDTH'(1);
                end
            end
        end
    end

    // A response on an idle entry is an upstream protocol error.
    rsp_on_free_entry: assert property (@(posedge clk_i) disable iff (rst_i)
        pop |-> (table_q[rsp_idx].cnt != '0))
        else $error("axi_id_remap_table: response on free entry %0d", rsp_idx);

    // Counters stay within their nominal width and the saturation limit.
    for (genvar g = 0; g < TABLE_SIZE; g++) begin : g_cnt_range
        cnt_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
            (32'(table_q[g].cnt) < (32'd1 << CW)) && (table_q[g].cnt <= CNT_LIMIT));
    end

endmodule

// File: rtl/axi_id_remap.sv
// AXI ID remapper: compresses wide crossbar IDs into a small output ID space
// using separate read and write remap tables; all channels are zero-latency.
module axi_id_remap
    import axi_id_remap_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH   = 32,
    parameter int unsigned AXI_DATA_WIDTH   = 32,
    parameter int unsigned AXI_USER_WIDTH   = 0,
    parameter int unsigned AXI_ID_IN_WIDTH  = 12,
    parameter int unsigned AXI_ID_OUT_WIDTH = 4,
    parameter int unsigned MAX_TXNS_PER_ID  = 4
) (
    input  logic   clk_i,
    input  logic   rst_i,
    AXI_BUS.Slave  slave,
    AXI_BUS.Master master
);

    localparam int unsigned USER_BITS = (AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1;

    // While reset is held no valid or ready leaves this block.
    logic run;
    assign run = !rst_i;

    logic                        aw_sel_valid;
    logic [AXI_ID_OUT_WIDTH-1:0] aw_sel_idx;
    logic                        aw_push;
    logic                        b_pop;
    logic [AXI_ID_IN_WIDTH-1:0]  b_in_id;

    logic                        ar_sel_valid;
    logic [AXI_ID_OUT_WIDTH-1:0] ar_sel_idx;
    logic                        ar_push;
    logic                        r_pop;
    logic [AXI_ID_IN_WIDTH-1:0]  r_in_id;

    // ---------------- AW: remapped ID, stall when no entry available
    assign master.aw_id     = aw_sel_idx;
    assign master.aw_addr   = slave.aw_addr;
    assign master.aw_len    = slave.aw_len;
    assign master.aw_size   = slave.aw_size;
    assign master.aw_burst  = slave.aw_burst;
    assign master.aw_lock   = slave.aw_lock;
    assign master.aw_cache  = slave.aw_cache;
    assign master.aw_prot   = slave.aw_prot;
    assign master.aw_qos    = slave.aw_qos;
    assign master.aw_region = slave.aw_region;
    assign master.aw_user   = slave.aw_user;
    assign master.aw_valid  = run & slave.aw_valid & aw_sel_valid;
    assign slave.aw_ready   = run & aw_sel_valid & master.aw_ready;
    assign aw_push          = master.aw_valid & master.aw_ready;

    // ---------------- W: straight through
    assign master.w_data  = slave.w_data;
    assign master.w_strb  = slave.w_strb;
    assign master.w_last  = slave.w_last;
    assign master.w_user  = slave.w_user;
    assign master.w_valid = run & slave.w_valid;
    assign slave.w_ready  = run & master.w_ready;

    // ---------------- B: ID translated back through the write table
    assign slave.b_id     = b_in_id;
    assign slave.b_resp   = master.b_resp;
    assign slave.b_user   = master.b_user;
    assign slave.b_valid  = run & master.b_valid;
    assign master.b_ready = run & slave.b_ready;
    assign b_pop          = slave.b_valid & slave.b_ready;

    // ---------------- AR: remapped ID, stall when no entry available
    assign master.ar_id     = ar_sel_idx;
    assign master.ar_addr   = slave.ar_addr;
    assign master.ar_len    = slave.ar_len;
    assign master.ar_size   = slave.ar_size;
    assign master.ar_burst  = slave.ar_burst;
    assign master.ar_lock   = slave.ar_lock;
    assign master.ar_cache  = slave.ar_cache;
    assign master.ar_prot   = slave.ar_prot;
    assign master.ar_qos    = slave.ar_qos;
    assign master.ar_region = slave.ar_region;
    assign master.ar_user   = slave.ar_user;
    assign master.ar_valid  = run & slave.ar_valid & ar_sel_valid;
    assign slave.ar_ready   = run & ar_sel_valid & master.ar_ready;
    assign ar_push          = master.ar_valid & master.ar_ready;

    // ---------------- R: ID translated back; only the last beat completes
    assign slave.r_id     = r_in_id;
    assign slave.r_data   = master.r_data;
    assign slave.r_resp   = master.r_resp;
    assign slave.r_last   = master.r_last;
    assign slave.r_user   = master.r_user;
    assign slave.r_valid  = run & master.r_valid;
    assign master.r_ready = run & slave.r_ready;
    assign r_pop          = slave.r_valid & slave.r_ready & master.r_last;

    axi_id_remap_table #(
        .ID_IN_WIDTH     (AXI_ID_IN_WIDTH),
        .ID_OUT_WIDTH    (AXI_ID_OUT_WIDTH),
        .MAX_TXNS_PER_ID (MAX_TXNS_PER_ID)
    ) u_wr_table (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_id    (slave.aw_id),
        .sel_valid (aw_sel_valid),
        .sel_idx   (aw_sel_idx),
        .push      (aw_push),
        .pop       (b_pop),
        .rsp_idx   (master.b_id),
        .rsp_in_id (b_in_id)
    );

    axi_id_remap_table #(
        .ID_IN_WIDTH     (AXI_ID_IN_WIDTH),
        .ID_OUT_WIDTH    (AXI_ID_OUT_WIDTH),
        .MAX_TXNS_PER_ID (MAX_TXNS_PER_ID)
    ) u_rd_table (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_id    (slave.ar_id),
        .sel_valid (ar_sel_valid),
        .sel_idx   (ar_sel_idx),
        .push      (ar_push),
        .pop       (r_pop),
        .rsp_idx   (master.r_id),
        .rsp_in_id (r_in_id)
    );

    // The bus bundles attached to the ports must agree with this block's
    // parameters, and the input ID must fit the table entry storage.
    bus_params_match: assert property (@(posedge clk_i)
        ($bits(slave.aw_id)    == AXI_ID_IN_WIDTH)  &&
        ($bits(master.aw_id)   == AXI_ID_OUT_WIDTH) &&
        ($bits(slave.aw_addr)  == AXI_ADDR_WIDTH)   &&
        ($bits(master.aw_addr) == AXI_ADDR_WIDTH)   &&
        ($bits(slave.w_data)   == AXI_DATA_WIDTH)   &&
        ($bits(master.w_data)  == AXI_DATA_WIDTH)   &&
        ($bits(slave.aw_user)  == USER_BITS)        &&
        ($bits(master.aw_user) == USER_BITS)        &&
        (AXI_ID_IN_WIDTH <= ID_MAX_WIDTH));

endmodule

// File: tb/tb_axi_id_remap.sv
// Directed scoreboard bench for axi_id_remap with a 4-entry table.
module tb_axi_id_remap;

    localparam int unsigned IW   = 12;
    localparam int unsigned OW   = 2;
    localparam int unsigned MAXT = 4;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [31:0]   data;
    } r_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(0)) slv ();
    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(OW), .AXI_USER_WIDTH(0)) mst ();

    axi_id_remap #(
        .AXI_ADDR_WIDTH   (32),
        .AXI_DATA_WIDTH   (32),
        .AXI_USER_WIDTH   (0),
        .AXI_ID_IN_WIDTH  (IW),
        .AXI_ID_OUT_WIDTH (OW),
        .MAX_TXNS_PER_ID  (MAXT)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .slave  (slv),
        .master (mst)
    );

    logic [OW-1:0] exp_aw_q [$];
    logic [OW-1:0] exp_ar_q [$];
    logic [IW-1:0] exp_b_q  [$];
    r_exp_t        exp_r_q  [$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare every handshake seen on the DUT outputs.
    always @(negedge clk) begin
        if (!rst) begin
            if (mst.aw_valid && mst.aw_ready) begin
                if (exp_aw_q.size() == 0) check("aw_unexpected", 64'(exp_aw_q.size()), 64'd1);
                else check("aw_out_id", 64'(mst.aw_id), 64'(exp_aw_q.pop_front()));
            end
            if (mst.ar_valid && mst.ar_ready) begin
                if (exp_ar_q.size() == 0) check("ar_unexpected", 64'(exp_ar_q.size()), 64'd1);
                else check("ar_out_id", 64'(mst.ar_id), 64'(exp_ar_q.pop_front()));
            end
            if (slv.b_valid && slv.b_ready) begin
                if (exp_b_q.size() == 0) check("b_unexpected", 64'(exp_b_q.size()), 64'd1);
                else check("b_in_id", 64'(slv.b_id), 64'(exp_b_q.pop_front()));
            end
            if (slv.r_valid && slv.r_ready) begin
                if (exp_r_q.size() == 0) check("r_unexpected", 64'(exp_r_q.size()), 64'd1);
                else check("r_id_data", 64'({slv.r_id, slv.r_data}), 64'(exp_r_q.pop_front()));
            end
        end
    end

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic aw_issue(input logic [IW-1:0] id, input logic [OW-1:0] exp);
        bit hs = 1'b0;
        exp_aw_q.push_back(exp);
        // NOTE: bench drives are blocking; they settle before the DUT samples.
        slv.aw_valid = 1'b1;
        slv.aw_id    = id;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (slv.aw_ready) begin hs = 1'b1; break; end
        end
        check("aw_handshake", 64'(hs), 64'd1);
        if (!hs) void'(exp_aw_q.pop_back());
        @(posedge clk); #1;
        slv.aw_valid = 1'b0;
    endtask

    task automatic ar_issue(input logic [IW-1:0] id, input logic [OW-1:0] exp);
        bit hs = 1'b0;
        exp_ar_q.push_back(exp);
        slv.ar_valid = 1'b1;
        slv.ar_id    = id;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (slv.ar_ready) begin hs = 1'b1; break; end
        end
        check("ar_handshake", 64'(hs), 64'd1);
        if (!hs) void'(exp_ar_q.pop_back());
        @(posedge clk); #1;
        slv.ar_valid = 1'b0;
    endtask

    task automatic b_issue(input logic [OW-1:0] idx, input logic [IW-1:0] exp);
        bit hs = 1'b0;
        exp_b_q.push_back(exp);
        mst.b_valid = 1'b1;
        mst.b_id    = idx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mst.b_ready) begin hs = 1'b1; break; end
        end
        check("b_handshake", 64'(hs), 64'd1);
        if (!hs) void'(exp_b_q.pop_back());
        @(posedge clk); #1;
        mst.b_valid = 1'b0;
    endtask

    task automatic r_issue(input logic [OW-1:0] idx, input logic last,
                           input logic [31:0] data, input logic [IW-1:0] exp);
        bit hs = 1'b0;
        exp_r_q.push_back('{id: exp, data: data});
        mst.r_valid = 1'b1;
        mst.r_id    = idx;
        mst.r_last  = last;
        mst.r_data  = data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mst.r_ready) begin hs = 1'b1; break; end
        end
        check("r_handshake", 64'(hs), 64'd1);
        if (!hs) void'(exp_r_q.pop_back());
        @(posedge clk); #1;
        mst.r_valid = 1'b0;
        mst.r_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // slave-port request side
        slv.aw_id = '0; slv.aw_addr = '0; slv.aw_len = '0; slv.aw_size = 3'd2;
        slv.aw_burst = 2'b01; slv.aw_lock = 1'b0; slv.aw_cache = '0; slv.aw_prot = '0;
        slv.aw_qos = '0; slv.aw_region = '0; slv.aw_user = '0; slv.aw_valid = 1'b0;
        slv.w_data = '0; slv.w_strb = '0; slv.w_last = 1'b0; slv.w_user = '0; slv.w_valid = 1'b0;
        slv.b_ready = 1'b1;
        slv.ar_id = '0; slv.ar_addr = '0; slv.ar_len = '0; slv.ar_size = 3'd2;
        slv.ar_burst = 2'b01; slv.ar_lock = 1'b0; slv.ar_cache = '0; slv.ar_prot = '0;
        slv.ar_qos = '0; slv.ar_region = '0; slv.ar_user = '0; slv.ar_valid = 1'b0;
        slv.r_ready = 1'b1;
        // master-port peripheral side
        mst.aw_ready = 1'b1; mst.w_ready = 1'b1; mst.ar_ready = 1'b1;
        mst.b_id = '0; mst.b_resp = '0; mst.b_user = '0; mst.b_valid = 1'b0;
        mst.r_id = '0; mst.r_data = '0; mst.r_resp = '0; mst.r_last = 1'b0;
        mst.r_user = '0; mst.r_valid = 1'b0;

        // ---- reset with traffic pending on every channel
        rst = 1'b1;
        slv.aw_valid = 1'b1; slv.aw_id = 12'h3A5;
        slv.ar_valid = 1'b1; slv.w_valid = 1'b1;
        mst.b_valid  = 1'b1; mst.r_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_quiet",
              64'({mst.aw_valid, slv.aw_ready, mst.ar_valid, slv.ar_ready, mst.w_valid,
                   slv.w_ready, slv.b_valid, mst.b_ready, slv.r_valid, mst.r_ready}),
              64'd0);
        slv.ar_valid = 1'b0; slv.w_valid = 1'b0;
        mst.b_valid  = 1'b0; mst.r_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        aw_issue(12'h3A5, 2'd0);
        b_issue(2'd0, 12'h3A5);

        // ---- W passthrough in both directions
        slv.w_valid = 1'b1; slv.w_data = 32'hCAFE_0123; slv.w_strb = 4'hA; slv.w_last = 1'b1;
        mst.w_ready = 1'b0;
        #1;
        check("w_forward", 64'({mst.w_valid, mst.w_data, mst.w_strb, mst.w_last}),
              64'({1'b1, 32'hCAFE_0123, 4'hA, 1'b1}));
        check("w_ready_low", 64'(slv.w_ready), 64'd0);
        mst.w_ready = 1'b1;
        #1;
        check("w_ready_high", 64'(slv.w_ready), 64'd1);
        slv.w_valid = 1'b0;
        @(posedge clk); #1;

        // ---- ordering: same ID reuses its entry, new ID takes the next free one
        slv.aw_addr = 32'h8000_0040; slv.aw_len = 8'd3; slv.aw_valid = 1'b1; slv.aw_id = 12'h011;
        #1;
        check("aw_fields", 64'({mst.aw_addr, mst.aw_len}), 64'({32'h8000_0040, 8'd3}));
        aw_issue(12'h011, 2'd0);
        aw_issue(12'h022, 2'd1);
        aw_issue(12'h011, 2'd0);
        b_issue(2'd1, 12'h022);
        b_issue(2'd0, 12'h011);
        b_issue(2'd0, 12'h011);

        // ---- read saturation: fifth AR on one ID stalls until a last beat
        for (int k = 0; k < 4; k++) ar_issue(12'h007, 2'd0);
        exp_ar_q.push_back(2'd0);
        slv.ar_valid = 1'b1; slv.ar_id = 12'h007;
        @(negedge clk);
        check("ar_sat_stall", 64'({slv.ar_ready, mst.ar_valid}), 64'd0);
        @(posedge clk); #1;
        mst.r_valid = 1'b1; mst.r_id = 2'd0; mst.r_last = 1'b1; mst.r_data = 32'h0000_5A5A;
        exp_r_q.push_back('{id: 12'h007, data: 32'h0000_5A5A});
        @(negedge clk);
        check("ar_free_same_cycle", 64'(slv.ar_ready), 64'd0);
        @(posedge clk); #1;
        mst.r_valid = 1'b0; mst.r_last = 1'b0;
        @(negedge clk);
        check("ar_released", 64'(slv.ar_ready), 64'd1);
        @(posedge clk); #1;
        slv.ar_valid = 1'b0;
        for (int k = 0; k < 4; k++) r_issue(2'd0, 1'b1, 32'h100 + 32'(k), 12'h007);

        // ---- multi-beat read: entry stays busy until the last beat
        ar_issue(12'h055, 2'd0);
        for (int k = 0; k < 3; k++) r_issue(2'd0, 1'b0, 32'hA0 + 32'(k), 12'h055);
        ar_issue(12'h066, 2'd1);
        r_issue(2'd0, 1'b1, 32'hA3, 12'h055);
        ar_issue(12'h077, 2'd0);
        r_issue(2'd1, 1'b1, 32'hB0, 12'h066);
        r_issue(2'd0, 1'b1, 32'hC0, 12'h077);

        // ---- AW and B handshake on the same entry in one cycle
        aw_issue(12'h0AA, 2'd0);
        exp_aw_q.push_back(2'd0);
        exp_b_q.push_back(12'h0AA);
        slv.aw_valid = 1'b1; slv.aw_id = 12'h0AA;
        mst.b_valid  = 1'b1; mst.b_id  = 2'd0;
        @(negedge clk);
        check("simul_ready", 64'({slv.aw_ready, mst.b_ready}), 64'd3);
        @(posedge clk); #1;
        slv.aw_valid = 1'b0; mst.b_valid = 1'b0;
        aw_issue(12'h0BB, 2'd1);
        b_issue(2'd0, 12'h0AA);
        aw_issue(12'h0CC, 2'd0);
        b_issue(2'd1, 12'h0BB);
        b_issue(2'd0, 12'h0CC);

        // ---- write table full: fifth distinct ID waits for a freed entry
        for (int k = 0; k < 4; k++) aw_issue(12'h100 + 12'(k), 2'(k));
        slv.aw_valid = 1'b1; slv.aw_id = 12'h104;
        @(negedge clk);
        check("aw_full_stall", 64'({slv.aw_ready, mst.aw_valid}), 64'd0);
        @(posedge clk); #1;
        b_issue(2'd2, 12'h102);
        aw_issue(12'h104, 2'd2);
        b_issue(2'd0, 12'h100);
        b_issue(2'd1, 12'h101);
        b_issue(2'd3, 12'h103);
        b_issue(2'd2, 12'h104);

        // ---- every expected transaction was consumed
        repeat (2) @(posedge clk);
        check("aw_queue_empty", 64'(exp_aw_q.size()), 64'd0);
        check("ar_queue_empty", 64'(exp_ar_q.size()), 64'd0);
        check("b_queue_empty",  64'(exp_b_q.size()),  64'd0);
        check("r_queue_empty",  64'(exp_r_q.size()),  64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
